// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: registered pc, {Z,N,C,V} status flags,
// a return-address stack for CALL/RET, and a run/halted/fault state machine.
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     branch_op,
    input  logic [ADDR_W-1:0]              target,
    input  logic                           flag_we,
    input  logic [3:0]                     alu_flags,
    output logic [ADDR_W-1:0]              pc,
    output logic [3:0]                     status,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           halted,
    output logic                           fault
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [3:0] OP_NEXT = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JEQ  = 4'd2;
    localparam logic [3:0] OP_JNE  = 4'd3;
    localparam logic [3:0] OP_JGT  = 4'd4;
    localparam logic [3:0] OP_JLT  = 4'd5;
    localparam logic [3:0] OP_JGE  = 4'd6;
    localparam logic [3:0] OP_JLE  = 4'd7;
    localparam logic [3:0] OP_JCS  = 4'd8;
    localparam logic [3:0] OP_JOV  = 4'd9;
    localparam logic [3:0] OP_CALL = 4'd10;
    localparam logic [3:0] OP_RET  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-1:0]                pc_q, pc_d, pc_inc;
    logic [SP_W-1:0]                  sp_q, sp_d;
    logic [3:0]                       status_q;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q;
    logic [PTR_W-1:0]                 wr_idx, top_idx;
    logic                             push;
    logic                             cond_taken;
    logic                             z, n, c, v;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign wr_idx  = sp_q[PTR_W-1:0];
    assign top_idx = PTR_W'(sp_q - SP_W'(1));
    assign {z, n, c, v} = status_q;

    // Conditions look at the flags held before this edge, so a same-cycle
    // flag_we cannot influence the branch it accompanies.
    always_comb begin
        cond_taken = 1'b0;
        case (branch_op)
            OP_JEQ:  cond_taken = z;
            OP_JNE:  cond_taken = !z;
            OP_JGT:  cond_taken = !z && !n;
            OP_JLT:  cond_taken = n;
            OP_JGE:  cond_taken = !n;
            OP_JLE:  cond_taken = z || n;
            OP_JCS:  cond_taken = c;
            OP_JOV:  cond_taken = v;
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        state_d = state_q;
        push    = 1'b0;
        if (state_q == ST_RUN) begin
            case (branch_op)
                OP_JMP: pc_d = target;
                OP_JEQ, OP_JNE, OP_JGT, OP_JLT,
                OP_JGE, OP_JLE, OP_JCS, OP_JOV:
                    pc_d = cond_taken ? target : pc_inc;
                OP_CALL: begin
                    if (sp_q == SP_FULL) begin
                        state_d = ST_FAULT;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = stack_q[top_idx];
                    end
                end
                OP_HALT: state_d = ST_HALTED;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            sp_q     <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            if (flag_we) status_q <= alu_flags;
        end
    end

    // Stack storage carries no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !rst) stack_q[wr_idx] <= pc_inc;
    end

    assign pc     = pc_q;
    assign status = status_q;
    assign sp     = sp_q;
    assign halted = (state_q == ST_HALTED);
    assign fault  = (state_q == ST_FAULT);

endmodule
